// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helper for the timer service stages.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int BCD_W    = 4;
    localparam int SEC_ONES = 0;
    localparam int SEC_TENS = 1;
    localparam int MIN_ONES = 2;
    localparam int MIN_TENS = 3;

    localparam logic [3:0] SEL_ALL  = 4'b1111;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    // Decrement mm:ss by one second, digit by digit with borrow. Loaded digits
    // are not normalised, so 00:95 steps to 00:94; only a digit that is
    // already 0 wraps (seconds tens to 5, every other digit to 9).
    function automatic logic [15:0] bcd_dec(input logic [15:0] value);
        logic [15:0] result;
        logic [3:0]  digit;
        logic        borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit = value[i*BCD_W +: BCD_W];
            if (borrow) begin
                if (digit == 4'd0) begin
                    result[i*BCD_W +: BCD_W] = (i == SEC_TENS) ? 4'd5 : 4'd9;
                    borrow = 1'b1;
                end else begin
                    result[i*BCD_W +: BCD_W] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Countdown step generator: counts 0..TICK_DIV-1 while enabled, ticks at the top.
// Latency: tick is combinational from the counter; counter updates each clk edge.
// Backpressure: none; enable freezes the count, clear forces it to zero.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Step counter: clear wins, otherwise advance and wrap only while enabled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == CNT_TOP) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = enable && (cnt == CNT_TOP);

endmodule

// File: rtl/countdown_service.sv
// Loads BCD mm:ss from the setter and counts it down at TICK_DIV under push control.
// Latency: load visible 1 cycle after finish1 rises; first step TICK_DIV cycles after start.
// Backpressure: none; push_c is a single-cycle pulse, load beats push in the same cycle.
module countdown_service
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        finish1,
    input  logic [15:0] time_in,
    input  logic        push_c,
    output logic [15:0] num,
    output logic [3:0]  sel,
    output logic        running,
    output logic        done
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] num_nxt;
    logic [3:0]  sel_nxt;
    logic        finish1_q;
    logic        armed;
    logic        load;
    logic        tick;
    logic        tick_en;
    logic        tick_clr;

    // A finish1 that is already high when reset releases must not count as a
    // rising edge, so loads are armed only once finish1 has been seen low.
    assign load     = finish1 && !finish1_q && armed;
    assign tick_en  = (state == ST_RUN) || (state == ST_DONE);
    assign tick_clr = load || (push_c && (state == ST_READY));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .resetn (resetn),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    // finish1 edge detection and load arming.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            finish1_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            finish1_q <= finish1;
            if (!finish1) begin
                armed <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load overrides everything; expiry beats a pause request.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = (time_in == 16'h0000) ? ST_DONE : ST_READY;
        end else begin
            case (state)
                ST_READY: if (push_c) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (tick && (num == 16'h0001)) begin
                        state_nxt = ST_DONE;
                    end else if (push_c) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (push_c) state_nxt = ST_RUN;
                ST_DONE:  if (push_c) state_nxt = ST_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    // Output next-values: count down on RUN ticks, blink the digits in DONE.
    always_comb begin
        num_nxt = num;
        sel_nxt = sel;
        if (load) begin
            num_nxt = time_in;
            sel_nxt = SEL_ALL;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        num_nxt = bcd_dec(num);
                    end
                end
                ST_DONE: begin
                    if (push_c) begin
                        num_nxt = 16'h0000;
                        sel_nxt = SEL_NONE;
                    end else if (tick) begin
                        sel_nxt = ~sel;
                    end
                end
                default: begin
                    num_nxt = num;
                    sel_nxt = sel;
                end
            endcase
        end
    end

    // Registered outputs; running/done follow the state on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            num     <= 16'h0000;
            sel     <= SEL_NONE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            num     <= num_nxt;
            sel     <= sel_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_countdown_service.sv
// Directed bench for countdown_service with TICK_DIV = 4.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: n/a.
module tb_countdown_service;

    logic        clk;
    logic        resetn;
    logic        finish1;
    logic [15:0] time_in;
    logic        push_c;
    logic [15:0] num;
    logic [3:0]  sel;
    logic        running;
    logic        done;

    int checks;
    int errors;

    countdown_service #(
        .TICK_DIV (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .finish1 (finish1),
        .time_in (time_in),
        .push_c  (push_c),
        .num     (num),
        .sel     (sel),
        .running (running),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        finish1 = 1'b0;
        push_c  = 1'b0;
        time_in = 16'h0000;
        wait_cyc(3);
        resetn = 1'b1;
        wait_cyc(1);
    endtask

    // Returns one falling edge after the edge that sampled the load.
    task automatic load(input logic [15:0] v);
        time_in = v;
        finish1 = 1'b1;
        wait_cyc(1);
        finish1 = 1'b0;
    endtask

    // Returns one falling edge after the edge that sampled push_c.
    task automatic pulse();
        push_c = 1'b1;
        wait_cyc(1);
        push_c = 1'b0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        finish1 = 1'b0;
        push_c  = 1'b0;
        time_in = 16'h0000;
        wait_cyc(3);
        checks++;
        if (num !== 16'h0000) begin errors++; $display("FAIL reset_num got=%h exp=0000", num); end
        checks++;
        if (sel !== 4'b0000) begin errors++; $display("FAIL reset_sel got=%b exp=0000", sel); end
        checks++;
        if ({running, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {running, done}); end
        resetn = 1'b1;
        wait_cyc(1);
        pulse();
        checks++;
        if ({sel, running, done} !== 6'b0) begin errors++; $display("FAIL idle_push got=%b exp=000000", {sel, running, done}); end
    endtask

    task automatic test_minute_borrow();
        do_reset();
        load(16'h0102);
        checks++;
        if ({num, sel} !== {16'h0102, 4'b1111}) begin errors++; $display("FAIL borrow_load got=%h/%b exp=0102/1111", num, sel); end
        pulse();
        wait_cyc(3);
        checks++;
        if ({num, running} !== {16'h0102, 1'b1}) begin errors++; $display("FAIL borrow_pre got=%h/%b exp=0102/1", num, running); end
        wait_cyc(1);
        checks++;
        if (num !== 16'h0101) begin errors++; $display("FAIL borrow_t4 got=%h exp=0101", num); end
        wait_cyc(4);
        checks++;
        if (num !== 16'h0100) begin errors++; $display("FAIL borrow_t8 got=%h exp=0100", num); end
        wait_cyc(4);
        checks++;
        if (num !== 16'h0059) begin errors++; $display("FAIL borrow_t12 got=%h exp=0059", num); end
    endtask

    task automatic test_expiry();
        do_reset();
        load(16'h0003);
        pulse();
        wait_cyc(11);
        checks++;
        if ({num, done} !== {16'h0001, 1'b0}) begin errors++; $display("FAIL expiry_pre got=%h/%b exp=0001/0", num, done); end
        wait_cyc(1);
        checks++;
        if ({num, done, running, sel} !== {16'h0000, 1'b1, 1'b0, 4'b1111}) begin
            errors++; $display("FAIL expiry_t12 got=%h/%b/%b/%b exp=0000/1/0/1111", num, done, running, sel);
        end
        wait_cyc(3);
        checks++;
        if (sel !== 4'b1111) begin errors++; $display("FAIL blink_hold got=%b exp=1111", sel); end
        wait_cyc(1);
        checks++;
        if (sel !== 4'b0000) begin errors++; $display("FAIL blink_off got=%b exp=0000", sel); end
        wait_cyc(4);
        checks++;
        if (sel !== 4'b1111) begin errors++; $display("FAIL blink_on got=%b exp=1111", sel); end
        pulse();
        checks++;
        if ({num, sel, done, running} !== {16'h0000, 4'b0000, 2'b00}) begin
            errors++; $display("FAIL expiry_ack got=%h/%b/%b/%b exp=0000/0000/0/0", num, sel, done, running);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        load(16'h0010);
        pulse();
        wait_cyc(5);
        pulse();
        checks++;
        if ({num, running} !== {16'h0009, 1'b0}) begin errors++; $display("FAIL pause_entry got=%h/%b exp=0009/0", num, running); end
        wait_cyc(20);
        checks++;
        if (num !== 16'h0009) begin errors++; $display("FAIL pause_hold got=%h exp=0009", num); end
        pulse();
        checks++;
        if ({num, running} !== {16'h0009, 1'b1}) begin errors++; $display("FAIL resume_entry got=%h/%b exp=0009/1", num, running); end
        wait_cyc(1);
        checks++;
        if (num !== 16'h0009) begin errors++; $display("FAIL resume_c1 got=%h exp=0009", num); end
        wait_cyc(1);
        checks++;
        if (num !== 16'h0008) begin errors++; $display("FAIL resume_c2 got=%h exp=0008", num); end
    endtask

    task automatic test_zero_load();
        do_reset();
        load(16'h0000);
        checks++;
        if ({done, running, sel, num} !== {1'b1, 1'b0, 4'b1111, 16'h0000}) begin
            errors++; $display("FAIL zero_load got=%b/%b/%b/%h exp=1/0/1111/0000", done, running, sel, num);
        end
    endtask

    task automatic test_priority_reset();
        do_reset();
        load(16'h0500);
        pulse();
        wait_cyc(2);
        time_in = 16'h0123;
        finish1 = 1'b1;
        push_c  = 1'b1;
        wait_cyc(1);
        finish1 = 1'b0;
        push_c  = 1'b0;
        checks++;
        if ({num, running, done, sel} !== {16'h0123, 1'b0, 1'b0, 4'b1111}) begin
            errors++; $display("FAIL prio_load got=%h/%b/%b/%b exp=0123/0/0/1111", num, running, done, sel);
        end
        pulse();
        wait_cyc(2);
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL prio_restart got=%b exp=1", running); end
        resetn  = 1'b0;
        finish1 = 1'b1;
        time_in = 16'h0777;
        wait_cyc(1);
        checks++;
        if ({num, sel, running, done} !== 22'd0) begin
            errors++; $display("FAIL mid_reset got=%h/%b/%b/%b exp=0000/0000/0/0", num, sel, running, done);
        end
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(3);
        checks++;
        if ({num, sel, done} !== 21'd0) begin errors++; $display("FAIL no_reload got=%h/%b/%b exp=0000/0000/0", num, sel, done); end
        finish1 = 1'b0;
        wait_cyc(1);
        load(16'h0042);
        checks++;
        if (num !== 16'h0042) begin errors++; $display("FAIL rearm_load got=%h exp=0042", num); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        finish1 = 1'b0;
        push_c  = 1'b0;
        time_in = 16'h0000;
        @(negedge clk);
        test_reset();
        test_minute_borrow();
        test_expiry();
        test_pause_resume();
        test_zero_load();
        test_priority_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
